disp_src_sel: RTL and testbench
===============================

# disp_src_sel

Parametrised display-source selector for the alarm-clock display path: it generalises the fixed time/alarm digit mux to NCH sources of WIDTH bits. The alarm button steps the selected channel, and a tick-based inactivity timeout returns the display to channel 0. While a non-default channel is shown, a blink flag is produced. It sits between the per-source digit generators (time, alarm, set modes) and the 7-segment decoder/scanner.

## Interface
- WIDTH, 4, bits per digit source
- NCH, 4, number of sources (2..16); channel 0 is the default (time) display
- SELW, 2, width of sel; must satisfy 2^SELW >= NCH
- TIMEOUT, 10, ticks without a press before returning to channel 0 (1..255)
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- tick  in  1  single-cycle enable pulse (nominally 1 Hz) used for timeout and blink
- buttonalam  in  1  alarm/mode button, already synchronised and debounced, level
- blink_en  in  1  enables blinking while sel != 0
- src  in  NCH*WIDTH  flattened sources; channel i occupies src[i*WIDTH +: WIDTH]
- num  out  WIDTH  registered selected digit
- sel  out  SELW  current channel index
- blank  out  1  blink phase; 1 = decoder shall blank the digit

## Operation
- Press detection: btn_q <= buttonalam every cycle. press = buttonalam & ~btn_q. btn_q resets to 1, so a button held through reset release is not a press.
- Channel stepping: on press, sel <= (sel == NCH-1) ? 0 : sel+1. sel never holds a value >= NCH.
- Timeout counter tcnt (8 bits):
  - cleared on press or whenever sel == 0;
  - otherwise incremented on tick;
  - when tick arrives with tcnt == TIMEOUT-1, sel <= 0 and tcnt <= 0.
- Simultaneous press and tick: press wins. sel steps, tcnt clears, and no timeout occurs in that cycle.
- Blink:
  - bph toggles on each tick while sel != 0 && blink_en;
  - bph is cleared when sel == 0 or blink_en == 0;
  - blank = bph, registered.
  - bph clears on any press, so a newly selected channel always starts visible.
- Output: num <= src[sel*WIDTH +: WIDTH] every cycle, using the registered sel. Source changes propagate even without a press.
- Reset values: sel=0, num=0, blank=0, tcnt=0, bph=0, btn_q=1.
- Reset asserted mid-operation overrides press, tick and timeout in the same cycle.

## Timing
- Press at rising edge k (buttonalam=1 sampled, btn_q=0): sel updates at edge k.
- num shows the new source at edge k+1, i.e. a 1-cycle latency from sel to num.
- Holding the button produces exactly one step; a release and re-press is required for the next step.
- A timeout return occurs at the edge sampling the TIMEOUT-th tick after the last press. num follows one cycle later.
- blank changes at the edge sampling tick. It is forced to 0 on the edge where sel becomes 0 or blink_en is sampled low.
- No combinational path from any input to any output.

## Test plan
- Reset with buttonalam=1 held, src={4'hD,4'hC,4'hB,4'hA}:
  - after reset sel=0, num=0, blank=0;
  - one cycle later num=4'hA;
  - releasing and pressing again gives sel=1 and then num=4'hB.
- Four separate presses with NCH=4: sel goes 1,2,3,0 (wrap).
  - num follows B,C,D,A, each one cycle after sel.
  - Holding the button for 20 cycles yields only one step.
- Set sel=2 with TIMEOUT=10 and no presses:
  - after 9 ticks sel=2;
  - on the 10th tick sel=0 and blank=0;
  - num=4'hA one cycle later.
- With sel=1, assert press and tick in the same cycle when tcnt=9: sel=2 and tcnt=0, with no return to 0.
  - 10 further ticks are needed before timeout.
- blink_en=1, sel=1: blank toggles 1,0,1 on successive ticks.
  - A press forces blank=0.
  - Dropping blink_en forces blank=0 on the next edge.
- Assert reset during the blink phase with sel=3 and tcnt=5: next edge gives sel=0, blank=0, num=0, tcnt=0.

Source files
------------

// File: rtl/disp_src_sel.sv
// disp_src_sel: selects one of NCH digit sources for the 7-segment path.
// The alarm button steps the channel. After TIMEOUT ticks without a press,
// the display returns to channel 0. While a non-default channel is shown,
// the blank output blinks on each tick.
module disp_src_sel #(
  parameter int WIDTH   = 4,
  parameter int NCH     = 4,
  parameter int SELW    = 2,
  parameter int TIMEOUT = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   buttonalam,
  input  logic                   blink_en,
  input  logic [NCH*WIDTH-1:0]   src,
  output logic [WIDTH-1:0]       num,
  output logic [SELW-1:0]        sel,
  output logic                   blank
);

  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);
  localparam logic [7:0]      TC_LAST = 8'(TIMEOUT - 1);

  logic             btn_q, btn_d;
  logic [SELW-1:0]  sel_q, sel_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic             bph_q, bph_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic             press;
  logic             timeout_hit;

  // Rising-edge press detect. btn_q resets high, so a button held across reset is ignored.
  always_comb begin
    btn_d       = buttonalam;
    press       = buttonalam & ~btn_q;
    timeout_hit = tick && (sel_q != '0) && (tcnt_q == TC_LAST) && !press;
  end

  // Channel stepping with wrap; a press takes priority over the timeout return.
  always_comb begin
    sel_d = sel_q;
    if (press) begin
      sel_d = (sel_q == LAST_CH) ? '0 : sel_q + SELW'(1);
    end else if (timeout_hit) begin
      sel_d = '0;
    end
  end

  // Inactivity counter: idle on channel 0, restarted by a press or a timeout.
  always_comb begin
    tcnt_d = tcnt_q;
    if (press || (sel_q == '0) || timeout_hit) begin
      tcnt_d = '0;
    end else if (tick) begin
      tcnt_d = tcnt_q + 8'd1;
    end
  end

  // Blink phase: toggles on tick and is held clear whenever blinking does not apply.
  always_comb begin
    bph_d = bph_q;
    if (press || (sel_q == '0) || !blink_en || timeout_hit) begin
      bph_d = 1'b0;
    end else if (tick) begin
      bph_d = ~bph_q;
    end
  end

  // Digit mux driven from the registered channel, giving one cycle of latency.
  always_comb begin
    num_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_q == SELW'(i)) begin
        num_d = src[i*WIDTH +: WIDTH];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q  <= 1'b1;
      sel_q  <= '0;
      tcnt_q <= '0;
      bph_q  <= 1'b0;
      num_q  <= '0;
    end else begin
      btn_q  <= btn_d;
      sel_q  <= sel_d;
      tcnt_q <= tcnt_d;
      bph_q  <= bph_d;
      num_q  <= num_d;
    end
  end

  assign num   = num_q;
  assign sel   = sel_q;
  assign blank = bph_q;

endmodule

// File: tb/tb_disp_src_sel.sv
// Testbench for disp_src_sel: directed sequences followed by random stimulus.
// A behavioural model predicts sel/num/blank for each clock edge, and a monitor checks the outputs.
module tb_disp_src_sel;

  localparam int WIDTH   = 4;
  localparam int NCH     = 4;
  localparam int SELW    = 2;
  localparam int TIMEOUT = 10;
  localparam int SW      = NCH * WIDTH;

  typedef struct {
    logic [SELW-1:0]  sel;
    logic [WIDTH-1:0] num;
    logic             blank;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             tick;
  logic             buttonalam;
  logic             blink_en;
  logic [SW-1:0]    src;
  logic [WIDTH-1:0] num;
  logic [SELW-1:0]  sel;
  logic             blank;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  // Behavioural model state
  int mSel     = 0;
  int mNum     = 0;
  int mBlank   = 0;
  int mIdle    = 0;
  int mPrevBtn = 1;

  disp_src_sel #(
    .WIDTH(WIDTH), .NCH(NCH), .SELW(SELW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .buttonalam(buttonalam),
    .blink_en(blink_en), .src(src), .num(num), .sel(sel), .blank(blank)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, predict the result of the next rising edge, queue it, then wait.
  task automatic applyStimulus(input logic r, input logic b, input logic t,
                               input logic e, input logic [SW-1:0] s);
    exp_t x;
    int   pressed;
    reset      = r;
    buttonalam = b;
    tick       = t;
    blink_en   = e;
    src        = s;
    if (r) begin
      mSel = 0; mNum = 0; mBlank = 0; mIdle = 0; mPrevBtn = 1;
    end else begin
      pressed = (b && !mPrevBtn) ? 1 : 0;
      mNum    = int'(s[mSel*WIDTH +: WIDTH]);
      if (pressed != 0) begin
        mSel   = (mSel + 1) % NCH;
        mIdle  = 0;
        mBlank = 0;
      end else if (mSel == 0) begin
        mIdle  = 0;
        mBlank = 0;
      end else begin
        if (t) mIdle = mIdle + 1;
        if (mIdle == TIMEOUT) begin
          mSel   = 0;
          mIdle  = 0;
          mBlank = 0;
        end else if (!e) begin
          mBlank = 0;
        end else if (t) begin
          mBlank = 1 - mBlank;
        end
      end
      mPrevBtn = b ? 1 : 0;
    end
    x.sel   = SELW'(mSel);
    x.num   = WIDTH'(mNum);
    x.blank = (mBlank != 0);
    expq.push_back(x);
    @(negedge clk);
  endtask

  // Compare one predicted response against the DUT outputs.
  task automatic checkOutput(input exp_t x);
    tests++;
    if (sel !== x.sel) begin
      fails++;
      $display("[TB] FAIL sel at %0t: got %0d expected %0d", $time, sel, x.sel);
    end
    tests++;
    if (num !== x.num) begin
      fails++;
      $display("[TB] FAIL num at %0t: got %h expected %h", $time, num, x.num);
    end
    tests++;
    if (blank !== x.blank) begin
      fails++;
      $display("[TB] FAIL blank at %0t: got %b expected %b", $time, blank, x.blank);
    end
  endtask

  // Monitor: after each rising edge, pop one prediction and compare.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        checkOutput(expq.pop_front());
      end else begin
        tests++;
        fails++;
        $display("[TB] FAIL scoreboard at %0t: got empty queue expected a prediction", $time);
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized run.
  initial begin
    logic [SW-1:0] s;
    logic          b, e;
    s = SW'(16'hDCBA);

    // Reset with the button held, then hold it longer: no step should occur.
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, s);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, s);
    // Release the button, then press and hold it for 20 cycles: exactly one step.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, s);
    repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, s);
    // Three more presses wrap 1 -> 2 -> 3 -> 0.
    repeat (3) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, s);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, s);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, s);
    end
    // Step to channel 2, then let 12 ticks pass so the display times out.
    repeat (2) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, s);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, s);
    end
    repeat (12) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, s);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, s);
    end
    // Step to channel 1, give 9 ticks, then press and tick together, then 11 more ticks.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, s);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, s);
    repeat (9) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, s);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, s);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, s);
    repeat (11) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, s);
    // Blink on channel 1, then drop blink_en.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, s);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, s);
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, s);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, s);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, s);
    // Move to channel 3, give 5 ticks while blinking, then reset mid-operation.
    repeat (2) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, s);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, s);
    end
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, s);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, s);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, s);

    // Randomized run.
    b = 1'b0;
    e = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0)  b = ~b;
      if ($urandom_range(0, 199) == 0) e = ~e;
      if ($urandom_range(0, 49) == 0)  s = SW'($urandom);
      applyStimulus(($urandom_range(0, 599) == 0), b,
                    ($urandom_range(0, 2) == 0), e, s);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
